ram_arbiter: RTL
================

# ram_arbiter

Shares the single-port 32-bit configuration RAM between `NUM_REQ` requesters, e.g. the SPI subordinate and an on-chip host port. It provides round-robin arbitration with an optional bounded lock for atomic sequences and one registered access stage. Each requester sees a valid/ready request channel and a one-cycle response pulse. The RAM side drives the existing `r_en`/`w_en`/`addr`/`data_o` and consumes combinational `data_i`, so the block sits directly in front of the RAM.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `ADDR_WIDTH`, 10: request address width, matching the SPI frame address field.
- `RAM_AW`, 8: implemented RAM address bits.
- `DATA_WIDTH`, 32: data width.
- `LOCK_MAX`, 16: maximum consecutive cycles one owner may hold a lock.

- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_lock`  in  NUM_REQ  hold ownership after this beat.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data.
- `req_ready`  out  NUM_REQ  one-hot accept; combinational from `req_valid` and arbiter state.
- `rsp_valid`  out  NUM_REQ  one-hot response pulse.
- `rsp_rdata`  out  DATA_WIDTH  read data, shared, qualified by `rsp_valid`.
- `rsp_err`  out  1  out-of-range access, qualified by `rsp_valid`.
- `r_en`, `w_en`  out  1  RAM read and write enables.
- `addr`  out  ADDR_WIDTH  RAM address. RAM uses [RAM_AW-1:0].
- `data_o`  out  DATA_WIDTH  RAM write data.
- `data_i`  in  DATA_WIDTH  RAM combinational read data.

## Operation
- A beat is accepted when `req_valid[i] && req_ready[i]`. At most one `req_ready` bit is high per cycle. A beat is never stalled by the response stage; one accept per cycle is possible.
- Round-robin: a priority pointer selects the first valid requester at or after the pointer, wrapping. After an accept, pointer = winner+1 mod NUM_REQ. Reset pointer = 0.
- FSM states:
  - ARB: normal round-robin.
    - Accept with `req_lock[w]`=1 → LOCKED, with owner=w and lock counter=0.
  - LOCKED: only the owner can get `req_ready`. Others wait. The counter increments every LOCKED cycle.
    - Exit to ARB when any of these holds:
      - the owner's accepted beat has `req_lock`=0;
      - owner `req_valid`=0 and `req_lock`=0;
      - counter reaches LOCK_MAX-1. This is a forced release: that cycle's beat is still served, and the pointer moves past the owner.
- Range check: if `req_addr[ADDR_WIDTH-1:RAM_AW]` is nonzero, the beat is accepted but `r_en`/`w_en` stay 0. The response then has `rsp_err`=1 and `rsp_rdata`=0.
- Writes also produce a `rsp_valid` pulse (write acknowledge), with `rsp_rdata`=0.
- Outputs when no command is in the access stage: `r_en`=`w_en`=0. `addr`/`data_o` hold their last value.

## Timing
- Cycle t: accept.
- Cycle t+1: registered command drives `r_en` or `w_en`, plus `addr` and `data_o`. The RAM write commits at the end of t+1. `data_i` is captured at the end of t+1.
- Cycle t+2: `rsp_valid[i]`=1 for exactly one cycle, together with `rsp_rdata`/`rsp_err`.
- Read-after-write: a write accepted at t and a read to the same address accepted at t+1 return the new data.
- Reset values:
  - all outputs 0;
  - FSM = ARB, pointer 0;
  - access and response stages empty.
- Reset asserted mid-operation: in-flight accesses are discarded and no `rsp_valid` is issued for them. The RAM contents are unaffected, apart from a write already committed at a prior edge.
- Requests arriving simultaneously are resolved by the pointer only. Lock requests do not get priority in ARB.

## Test plan
- Write, then read: requester 0 writes 0xCAFEBABE to 0x034 at t, then reads 0x034. Required: `w_en` at t+1, `rsp_valid`[0] at t+2, and the read returns 0xCAFEBABE with `rsp_err`=0.
- Contention: both requesters hold `req_valid` for 4 cycles, reading 0x034 and 0x035. Required: grants alternate 0,1,0,1 from reset, each response arrives 2 cycles after its grant, and the data is correct.
- Back-to-back RAW: requester 1 writes 0x12345678 to 0x0FF and reads 0x0FF on the next cycle. Required: the read returns 0x12345678.
- Lock: requester 1 issues 3 locked beats and then an unlocked beat, while requester 0 requests continuously. Required: requester 0 gets no ready until after the 4th beat of requester 1.
- Lock timeout: requester 0 holds `req_lock`=1 with LOCK_MAX=16. Required: forced release after 16 cycles, and requester 1 is granted next.
- Out-of-range and reset: a read of 0x134 gives `rsp_err`=1, `rsp_rdata`=0, and `r_en` never high. Asserting `rst_n`=0 in cycle t+1 of a read gives no `rsp_valid` and all outputs 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with bounded lock in front of the single-port config RAM.
// One registered access stage drives the RAM; responses pulse two cycles after accept.
module ram_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RAM_AW     = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ-1:0]              req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic                            r_en,
    output logic                            w_en,
    output logic [ADDR_WIDTH-1:0]           addr,
    output logic [DATA_WIDTH-1:0]           data_o,
    input  logic [DATA_WIDTH-1:0]           data_i
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SW = IW + 1;
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {ARB, LOCKED} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] rr_rot;
    logic [SW-1:0]      rr_sum;
    logic [IW-1:0]      rr_id;
    logic               rr_found;

    // Rotate valids so the pointer sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rr_rot   = NUM_REQ'({req_valid, req_valid} >> ptr_q);
        rr_found = 1'b0;
        rr_sum   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!rr_found && rr_rot[k]) begin
                rr_found = 1'b1;
                rr_sum   = {1'b0, ptr_q} + SW'(k);
            end
        end
        rr_id = (rr_sum >= SW'(NUM_REQ)) ? IW'(rr_sum - SW'(NUM_REQ)) : IW'(rr_sum);
    end

    logic                  sel_vld, sel_we, sel_lock, sel_err;
    logic [IW-1:0]         sel_id, sel_inc;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    always_comb begin
        sel_id  = '0;
        sel_vld = 1'b0;
        if (state_q == LOCKED) begin
            sel_id  = owner_q;
            sel_vld = req_valid[owner_q];
        end else begin
            sel_id  = rr_id;
            sel_vld = rr_found;
        end
        req_ready         = '0;
        req_ready[sel_id] = sel_vld;

        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel_id == IW'(i)) begin
                sel_we    = req_we[i];
                sel_lock  = req_lock[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        sel_err = |sel_addr[ADDR_WIDTH-1:RAM_AW];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        sel_inc = (sel_id == IW'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
        if (sel_vld) ptr_d = sel_inc;
        case (state_q)
            ARB: begin
                if (sel_vld && sel_lock) begin
                    state_d = LOCKED;
                    owner_d = sel_id;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                // sel_* track the owner here; a dropped lock releases whether or not a beat was taken
                if (cnt_q == CW'(LOCK_MAX - 1)) begin
                    state_d = ARB;
                    ptr_d   = sel_inc;
                end else if (!sel_lock) begin
                    state_d = ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    logic                  acc_vld_q, acc_we_q, acc_err_q;
    logic [IW-1:0]         acc_id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_vld_q, rsp_err_q;
    logic [IW-1:0]         rsp_id_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_vld_q <= 1'b0;
            acc_we_q  <= 1'b0;
            acc_err_q <= 1'b0;
            acc_id_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_id_q  <= '0;
            rdata_q   <= '0;
        end else begin
            acc_vld_q <= sel_vld;
            if (sel_vld) begin
                acc_we_q  <= sel_we;
                acc_err_q <= sel_err;
                acc_id_q  <= sel_id;
                addr_q    <= sel_addr;
                wdata_q   <= sel_wdata;
            end
            rsp_vld_q <= acc_vld_q;
            if (acc_vld_q) begin
                rsp_id_q  <= acc_id_q;
                rsp_err_q <= acc_err_q;
                rdata_q   <= (acc_we_q || acc_err_q) ? '0 : data_i;
            end
        end
    end

    assign r_en      = acc_vld_q & ~acc_we_q & ~acc_err_q;
    assign w_en      = acc_vld_q &  acc_we_q & ~acc_err_q;
    assign addr      = addr_q;
    assign data_o    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        rsp_valid           = '0;
        rsp_valid[rsp_id_q] = rsp_vld_q;
    end

endmodule
